// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pc_unit shared definitions
// widths, FSM encoding, trap cause
package fetch_pc_unit_pkg;

   localparam int XLEN        = 64;
   localparam int INSTR_BYTES = 4;

   localparam logic [XLEN-1:0] CAUSE_INSTR_MISALIGNED = '0;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      TRAP = 2'd2
   } state_t;

   function automatic logic is_misaligned(input logic [1:0] lo);
      return lo != 2'b00;
   endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit control/redirect bundle
// master = controller side, slave = PC unit
interface fetch_pc_unit_if #(
   parameter int XLEN = 64
);

   logic            stall;
   logic            branch_taken;
   logic [XLEN-1:0] branch_target;
   logic            jump_taken;
   logic            jump_is_jalr;
   logic [XLEN-1:0] jump_target;
   logic            trap_ack;
   logic [XLEN-1:0] instr_address;
   logic [XLEN-1:0] pc_plus4;
   logic            fetch_valid;
   logic            trap_pending;
   logic [XLEN-1:0] trap_epc;
   logic [XLEN-1:0] trap_tval;
   logic [63:0]     instret;

   modport master (
      output stall, branch_taken, branch_target,
      output jump_taken, jump_is_jalr, jump_target,
      output trap_ack,
      input  instr_address, pc_plus4, fetch_valid,
      input  trap_pending, trap_epc, trap_tval, instret
   );

   modport slave (
      input  stall, branch_taken, branch_target,
      input  jump_taken, jump_is_jalr, jump_target,
      input  trap_ack,
      output instr_address, pc_plus4, fetch_valid,
      output trap_pending, trap_epc, trap_tval, instret
   );

endinterface

// File: rtl/fetch_pc_unit_next_pc_select.sv
// next-PC priority mux: jump > branch > PC+4
// JALR bit-0 clear and misaligned-target detect
import fetch_pc_unit_pkg::*;

module next_pc_select #(
   parameter int              XLEN        = fetch_pc_unit_pkg::XLEN,
   parameter logic [XLEN-1:0] TRAP_VECTOR = 'h100
) (
   input  logic [XLEN-1:0] pc,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   input  logic            jump_taken,
   input  logic            jump_is_jalr,
   input  logic [XLEN-1:0] jump_target,
   output logic [XLEN-1:0] next_pc,
   output logic            misaligned,
   output logic [XLEN-1:0] tval
);

   logic [XLEN-1:0] jmp_eff;
   logic [XLEN-1:0] tgt;
   logic            redirect;

   // pick redirect target, fall back to sequential, trap on bad alignment
   always_comb begin
      jmp_eff    = jump_target;
      tgt        = '0;
      redirect   = 1'b0;
      if (jump_is_jalr) jmp_eff[0] = 1'b0;
      if (jump_taken) begin
         tgt      = jmp_eff;
         redirect = 1'b1;
      end else if (branch_taken) begin
         tgt      = branch_target;
         redirect = 1'b1;
      end
      misaligned = redirect && is_misaligned(tgt[1:0]);
      tval       = tgt;
      if (misaligned)    next_pc = TRAP_VECTOR;
      else if (redirect) next_pc = tgt;
      else               next_pc = pc + XLEN'(INSTR_BYTES);
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// PC register, BOOT/RUN/TRAP FSM, trap capture
// and retired-instruction counter
import fetch_pc_unit_pkg::*;

module fetch_pc_unit #(
   parameter int              XLEN        = fetch_pc_unit_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC    = '0,
   parameter logic [XLEN-1:0] TRAP_VECTOR = 'h100
) (
   input logic             clk,
   input logic             rst,
   fetch_pc_unit_if.slave  bus
);

   state_t          state;
   state_t          state_nx;
   logic            advance;
   logic            fv;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] next_pc;
   logic            mis;
   logic [XLEN-1:0] tval_w;
   logic            pend;
   logic [XLEN-1:0] epc;
   logic [XLEN-1:0] tval;
   logic [63:0]     cnt;

   next_pc_select #(
      .XLEN        (XLEN),
      .TRAP_VECTOR (TRAP_VECTOR)
   ) u_sel (
      .pc            (pc),
      .branch_taken  (bus.branch_taken),
      .branch_target (bus.branch_target),
      .jump_taken    (bus.jump_taken),
      .jump_is_jalr  (bus.jump_is_jalr),
      .jump_target   (bus.jump_target),
      .next_pc       (next_pc),
      .misaligned    (mis),
      .tval          (tval_w)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst) state <= BOOT;
      else      state <= state_nx;
   end

   // FSM next state; a stall freezes state along with the PC
   always_comb begin
      state_nx = state;
      fv       = 1'b0;
      advance  = 1'b0;
      unique case (state)
         BOOT: begin
            if (!bus.stall) state_nx = RUN;
         end
         RUN: begin
            fv      = !bus.stall;
            advance = !bus.stall;
            if (advance && mis) state_nx = TRAP;
         end
         TRAP: begin
            fv      = !bus.stall;
            advance = !bus.stall;
            if (advance && !mis && bus.trap_ack) state_nx = RUN;
         end
         default: state_nx = BOOT;
      endcase
   end

   // PC, counter and trap capture; a new trap beats a same-cycle ack
   always_ff @(posedge clk) begin
      if (!rst) begin
         pc   <= RESET_PC;
         cnt  <= '0;
         pend <= 1'b0;
         epc  <= '0;
         tval <= '0;
      end else begin
         if (advance) begin
            pc  <= next_pc;
            cnt <= cnt + 64'd1;
         end
         if (advance && mis) begin
            pend <= 1'b1;
            epc  <= pc;
            tval <= tval_w;
         end else if (bus.trap_ack) begin
            pend <= 1'b0;
         end
      end
   end

   assign bus.instr_address = pc;
   assign bus.pc_plus4      = pc + XLEN'(INSTR_BYTES);
   assign bus.fetch_valid   = fv && rst;
   assign bus.trap_pending  = pend;
   assign bus.trap_epc      = epc;
   assign bus.trap_tval     = tval;
   assign bus.instret       = cnt;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// fetch_pc_unit bench: directed steps,
// expectations queued then checked after each edge
module tb_fetch_pc_unit;

   logic clk = 1'b0;
   logic rst = 1'b0;

   fetch_pc_unit_if #(.XLEN(64)) bus ();

   fetch_pc_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic        fv;
      logic [63:0] pc;
      logic [63:0] p4;
      logic        pend;
      logic [63:0] epc;
      logic [63:0] tval;
      logic [63:0] cnt;
   } exp_t;

   exp_t sb[$];

   int n_vec = 0;
   int n_err = 0;

   logic        m_pend = 1'b0;
   logic [63:0] m_epc  = '0;
   logic [63:0] m_tval = '0;
   logic [63:0] m_cnt  = '0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step(input string tag,
                       input logic st, input logic br,
                       input logic [63:0] bt, input logic j,
                       input logic jalr, input logic [63:0] jt,
                       input logic ack, input logic [63:0] exp_pc,
                       input logic exp_fv);
      exp_t e;
      exp_t g;
      logic fv_seen;
      @(negedge clk);
      bus.stall         = st;
      bus.branch_taken  = br;
      bus.branch_target = bt;
      bus.jump_taken    = j;
      bus.jump_is_jalr  = jalr;
      bus.jump_target   = jt;
      bus.trap_ack      = ack;
      #1;
      fv_seen = bus.fetch_valid;
      if (exp_fv) m_cnt = m_cnt + 64'd1;
      e.tag  = tag;
      e.fv   = exp_fv;
      e.pc   = exp_pc;
      e.p4   = exp_pc + 64'd4;
      e.pend = m_pend;
      e.epc  = m_epc;
      e.tval = m_tval;
      e.cnt  = m_cnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 64'd1, 64'd0);
      end else begin
         g = sb.pop_front();
         chk({g.tag, "_fv"},   {63'd0, fv_seen},          {63'd0, g.fv});
         chk({g.tag, "_pc"},   bus.instr_address,         g.pc);
         chk({g.tag, "_p4"},   bus.pc_plus4,              g.p4);
         chk({g.tag, "_pend"}, {63'd0, bus.trap_pending}, {63'd0, g.pend});
         chk({g.tag, "_epc"},  bus.trap_epc,              g.epc);
         chk({g.tag, "_tval"}, bus.trap_tval,             g.tval);
         chk({g.tag, "_cnt"},  bus.instret,               g.cnt);
      end
   endtask

   task automatic idle(input string tag, input logic [63:0] exp_pc,
                       input logic exp_fv);
      step(tag, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0,
           exp_pc, exp_fv);
   endtask

   task automatic jmp(input string tag, input logic jalr,
                      input logic [63:0] jt, input logic [63:0] exp_pc);
      step(tag, 1'b0, 1'b0, 64'd0, 1'b1, jalr, jt, 1'b0, exp_pc, 1'b1);
   endtask

   task automatic clr_model();
      m_pend = 1'b0;
      m_epc  = '0;
      m_tval = '0;
      m_cnt  = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired n_vec=%0d", n_vec);
      $fatal(1);
   end

   initial begin
      bus.stall         = 1'b0;
      bus.branch_taken  = 1'b0;
      bus.branch_target = '0;
      bus.jump_taken    = 1'b0;
      bus.jump_is_jalr  = 1'b0;
      bus.jump_target   = '0;
      bus.trap_ack      = 1'b0;

      // reset and boot bubble
      rst = 1'b0;
      clr_model();
      idle("rst0", 64'h0, 1'b0);
      idle("rst1", 64'h0, 1'b0);
      rst = 1'b1;
      idle("boot", 64'h0, 1'b0);
      idle("seq4", 64'h4, 1'b1);
      idle("seq8", 64'h8, 1'b1);
      idle("seq12", 64'hC, 1'b1);

      // priority at PC=8
      jmp("to8", 1'b0, 64'h8, 64'h8);
      step("prio", 1'b0, 1'b1, 64'h40, 1'b1, 1'b0, 64'h80, 1'b0,
           64'h80, 1'b1);

      // JALR masking, then misaligned JAL
      jmp("jalr41", 1'b1, 64'h41, 64'h40);
      jmp("to10", 1'b0, 64'h10, 64'h10);
      m_pend = 1'b1; m_epc = 64'h10; m_tval = 64'h42;
      jmp("jal42", 1'b0, 64'h42, 64'h100);
      idle("trap_seq", 64'h104, 1'b1);
      m_pend = 1'b0;
      step("ack", 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b1,
           64'h108, 1'b1);

      // stall with a pending branch that must be ignored
      jmp("to20", 1'b0, 64'h20, 64'h20);
      for (int i = 0; i < 3; i++)
         step("stall", 1'b1, 1'b1, 64'h60, 1'b0, 1'b0, 64'd0, 1'b0,
              64'h20, 1'b0);
      idle("unstall", 64'h24, 1'b1);

      // re-trap while pending, and trap beating ack
      m_pend = 1'b1; m_epc = 64'h24; m_tval = 64'h62;
      step("br62", 1'b0, 1'b1, 64'h62, 1'b0, 1'b0, 64'd0, 1'b0,
           64'h100, 1'b1);
      m_epc = 64'h100; m_tval = 64'h42;
      jmp("jalr43", 1'b1, 64'h43, 64'h100);
      m_tval = 64'h6;
      step("ack_vs_trap", 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 64'h6, 1'b1,
           64'h100, 1'b1);
      m_pend = 1'b0;
      step("ack_stall", 1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b1,
           64'h100, 1'b0);
      idle("post_ack", 64'h104, 1'b1);
      m_pend = 1'b1; m_epc = 64'h104; m_tval = 64'hA;
      jmp("jmpA", 1'b0, 64'hA, 64'h100);
      idle("trap104", 64'h104, 1'b1);

      // reset mid-trap
      rst = 1'b0;
      clr_model();
      idle("rst_mid", 64'h0, 1'b0);
      rst = 1'b1;
      idle("boot2", 64'h0, 1'b0);
      idle("seq4b", 64'h4, 1'b1);

      // plain branch, then wrap-around
      step("br200", 1'b0, 1'b1, 64'h200, 1'b0, 1'b0, 64'd0, 1'b0,
           64'h200, 1'b1);
      jmp("to_top", 1'b0, 64'hFFFF_FFFF_FFFF_FFFC,
          64'hFFFF_FFFF_FFFF_FFFC);
      idle("wrap", 64'h0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Program-counter and next-PC stage for the single-cycle RV64 core.
- Sits directly upstream of instruction_memory and drives its instr_address every cycle.
- Selects the next PC from sequential, branch, or jump (JAL/JALR) sources, and supports a stall.
- Detects misaligned control-flow targets, redirects to a trap vector, and counts issued instructions.

Parameters:
- XLEN, 64, address/PC width.
- RESET_PC, 64'h0, PC value loaded on reset.
- TRAP_VECTOR, 64'h100, PC loaded on a misaligned-target trap.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 at posedge resets).
- stall  in  1  hold PC; redirects are ignored while high.
- branch_taken  in  1  conditional branch resolved taken this cycle.
- branch_target  in  XLEN  branch destination.
- jump_taken  in  1  JAL/JALR this cycle.
- jump_is_jalr  in  1  jump is JALR; bit 0 of target is cleared before use.
- jump_target  in  XLEN  jump destination.
- trap_ack  in  1  clears a pending trap.
- instr_address  out  XLEN  current PC, fed to instruction_memory.
- pc_plus4  out  XLEN  instr_address+4 (link value).
- fetch_valid  out  1  current instr_address holds an instruction to execute.
- trap_pending  out  1  sticky misaligned-target trap flag.
- trap_epc  out  XLEN  PC of the instruction that caused the trap.
- trap_tval  out  XLEN  offending (post-mask) target address.
- instret  out  64  count of cycles with fetch_valid=1 and stall=0.

Behaviour:
- Reset (rst==0 at posedge) sets:
  - instr_address=RESET_PC, trap_pending=0, trap_epc=0, trap_tval=0, instret=0, state=BOOT.
  - fetch_valid=0 while in reset.
- FSM states: BOOT, RUN, TRAP.
  - BOOT: one bubble cycle after reset release; fetch_valid=0, PC held; next state RUN.
  - RUN: fetch_valid=!stall.
  - TRAP: entered the cycle after a misaligned redirect. PC advances normally from TRAP_VECTOR and fetch_valid=!stall. Returns to RUN on trap_ack=1.
- Next-PC priority, evaluated only when state!=BOOT and stall=0:
  - jump_taken > branch_taken > sequential (PC+4).
  - Effective jump target = jump_is_jalr ? {jump_target[XLEN-1:1],1'b0} : jump_target.
- Misalignment check: the selected redirect target has bits [1:0]!=2'b00. On detection:
  - next PC=TRAP_VECTOR.
  - trap_pending<=1, trap_epc<=current instr_address, trap_tval<=masked target.
  - state<=TRAP.
- Misaligned redirect while trap_pending=1:
  - PC still goes to TRAP_VECTOR.
  - trap_epc/trap_tval are overwritten.
  - trap_pending stays 1.
- trap_ack=1 and a new misaligned redirect in the same cycle: the new trap wins (trap_pending stays 1, fields updated).
- trap_ack while stalled still clears trap_pending.
- stall=1: instr_address, state and instret hold; all redirect inputs are ignored that cycle. The controller must re-present the redirect after the stall.
- Arithmetic:
  - PC+4 wraps modulo 2^XLEN (64'hFFFF_FFFF_FFFF_FFFC -> 0), no flag.
  - instret wraps modulo 2^64.
- pc_plus4 is combinational from instr_address.
- Latency:
  - Redirect inputs sampled at posedge N appear on instr_address after posedge N.
  - Zero combinational path from inputs to instr_address.
- Reset mid-stall or mid-trap: reset fully overrides; all state returns to reset values.

Decomposition:
- Shared core package holds:
  - XLEN.
  - INSTR_BYTES=4.
  - FSM state encoding (BOOT/RUN/TRAP, 2 bits).
  - Trap cause constant CAUSE_INSTR_MISALIGNED=0.
- One natural sub-module, next_pc_select: combinational priority mux plus JALR masking and misalignment detect. Outputs next_pc, misaligned, tval.
- Registers and the FSM live in fetch_pc_unit.

Test Plan:
- Reset and boot:
  - Stimulus: rst=0 for 2 cycles, then rst=1.
  - Required: instr_address=0, fetch_valid=0 for one cycle, then fetch_valid=1.
  - Required: instr_address steps 0,4,8,12 on successive cycles; instret=3 after the third fetched cycle.
- Branch vs jump priority:
  - Stimulus: at PC=8, branch_taken=1 target 0x40 and jump_taken=1 target 0x80 in the same cycle.
  - Required: next instr_address=0x80; pc_plus4=0x84.
- JALR masking and misalignment:
  - JALR to 0x41 -> PC=0x40, no trap.
  - JAL to 0x42 from PC=0x10 -> PC=0x100, trap_pending=1, trap_epc=0x10, trap_tval=0x42.
  - trap_ack -> trap_pending=0.
- Stall:
  - Stimulus: stall=1 for 3 cycles at PC=0x20 with branch_taken=1 target 0x60.
  - Required: PC stays 0x20, instret frozen, fetch_valid=0.
  - After release with no redirect -> PC=0x24.
- Wrap-around:
  - Stimulus: jump to 64'hFFFF_FFFF_FFFF_FFFC.
  - Required: next sequential PC=0.
- Reset mid-trap:
  - Stimulus: trap_pending=1 at PC=0x104, then assert rst=0 for one cycle.
  - Required: all outputs return to reset values; BOOT bubble repeats.
